// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I integer subset core sharing one req/ready memory port for fetch and data.
// Optional feature macro: MIPS_MC_LINK_EN adds jal/jr; without it both decode as illegal.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retired,
  output logic        halted,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnOr    = 6'h25;
  localparam logic [5:0] FnSlt   = 6'h2a;
`ifdef MIPS_MC_LINK_EN
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] FnJr    = 6'h08;
`endif

  state_e      state;
  logic [31:0] pc, ir, a, b, alu_out, mdr, wait_cnt;
  logic [31:0] gpr [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wr_reg;
  logic [15:0] imm;
  logic [31:0] imm_sext, br_target, br_next, j_target, alu_res, wb_data;
  logic        legal, timeout;

  assign op        = ir[31:26];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign funct     = ir[5:0];
  assign imm       = ir[15:0];
  assign imm_sext  = {{16{imm[15]}}, imm};
  // pc already points past the branch when this is used
  assign br_target = pc + {imm_sext[29:0], 2'b00};
  assign br_next   = (a == b) ? br_target : pc;
  assign j_target  = {pc[31:28], ir[25:0], 2'b00};
  assign wr_reg    = (op == OpRtype) ? rd : rt;
  assign wb_data   = (op == OpLw) ? mdr : alu_out;
  assign timeout   = (WAIT_MAX != 32'd0) && (wait_cnt == 32'(WAIT_MAX - 1));

  always_comb begin
    alu_res = a + imm_sext;
    case (op)
      OpRtype: begin
        case (funct)
          FnSubu:  alu_res = a - b;
          FnAnd:   alu_res = a & b;
          FnOr:    alu_res = a | b;
          FnSlt:   alu_res = {31'b0, $signed(a) < $signed(b)};
          default: alu_res = a + b;
        endcase
      end
      OpOri:   alu_res = a | {16'b0, imm};
      OpLui:   alu_res = {imm, 16'b0};
      default: ;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAddu, FnSubu, FnAnd, FnOr, FnSlt: legal = 1'b1;
`ifdef MIPS_MC_LINK_EN
          FnJr:    legal = 1'b1;
`endif
          default: legal = 1'b0;
        endcase
      end
      OpJ, OpBeq, OpAddiu, OpOri, OpLui, OpLw, OpSw: legal = 1'b1;
`ifdef MIPS_MC_LINK_EN
      OpJal:   legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StBoot;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      wait_cnt  <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      retired   <= 1'b0;
      halted    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      retired <= 1'b0;
      case (state)
        StBoot: begin
          state    <= StFetch;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
        end
        StFetch, StMem: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state == StFetch) begin
              ir      <= mem_rdata;
              pc      <= pc + 32'd4;
              mem_req <= 1'b0;
              state   <= StDecode;
            end else if (op == OpSw) begin
              retired  <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
              state    <= StFetch;
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= StWb;
            end
          end else if (timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            halted  <= 1'b1;
            bus_err <= 1'b1;
            state   <= StHalt;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        StDecode: begin
          a <= gpr[rs];
          b <= gpr[rt];
          if (!legal) begin
            halted <= 1'b1;
            state  <= StHalt;
          end else if (op == OpJ) begin
            pc       <= j_target;
            mem_addr <= j_target;
            mem_req  <= 1'b1;
            retired  <= 1'b1;
            state    <= StFetch;
`ifdef MIPS_MC_LINK_EN
          end else if (op == OpJal) begin
            gpr[31]  <= pc;
            pc       <= j_target;
            mem_addr <= j_target;
            mem_req  <= 1'b1;
            retired  <= 1'b1;
            state    <= StFetch;
          end else if (op == OpRtype && funct == FnJr) begin
            pc       <= {gpr[rs][31:2], 2'b00};
            mem_addr <= {gpr[rs][31:2], 2'b00};
            mem_req  <= 1'b1;
            retired  <= 1'b1;
            state    <= StFetch;
`endif
          end else begin
            state <= StExec;
          end
        end
        StExec: begin
          alu_out <= alu_res;
          if (op == OpBeq) begin
            pc       <= br_next;
            mem_addr <= br_next;
            mem_req  <= 1'b1;
            retired  <= 1'b1;
            state    <= StFetch;
          end else if (op == OpLw || op == OpSw) begin
            mem_req   <= 1'b1;
            mem_we    <= (op == OpSw);
            mem_addr  <= {alu_res[31:2], 2'b00};
            mem_wdata <= b;
            state     <= StMem;
          end else begin
            state <= StWb;
          end
        end
        StWb: begin
          if (wr_reg != 5'd0) gpr[wr_reg] <= wb_data;
          retired  <= 1'b1;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= pc;
          state    <= StFetch;
        end
        default: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
          state   <= StHalt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: a word memory model with configurable wait states,
// vector tables for results and bus transfers, plus hand sequences for timeout and halts.
module tb_mips_multicycle;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } mvec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  localparam logic [31:0] Sentinel = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, retired, halted, bus_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] mem [0:4095];
  logic [31:0] prog [$];
  int          waits = 0;
  bit          stall = 1'b0;
  int          wcnt  = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  xfer_t       xlog [$];
  int          rlog [$];

  mvec_t mv [7];
  xfer_t xexp [12];

  mips_multicycle #(.RESET_PC(32'h0000_3000), .WAIT_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retired   (retired),
    .halted    (halted),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Memory model: responds at the negedge so the DUT samples a settled mem_ready.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end else begin
      if (wcnt == 0) begin
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
      end else begin
        check("hold_addr", mem_addr, hold_addr);
        check_bit("hold_we", mem_we, hold_we);
        check("hold_wdata", mem_wdata, hold_wdata);
      end
      if (!stall && wcnt >= waits) begin
        xfer_t x;
        x.we = mem_we;
        x.addr = mem_addr;
        x.data = mem_wdata;
        xlog.push_back(x);
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[13:2]];
        if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end
    if (!rst && retired) rlog.push_back(cyc);
  end

  task automatic load_prog();
    for (int i = 0; i < 4096; i++) mem[i] = Sentinel;
    for (int i = 0; i < prog.size(); i++) mem[3072 + i] = prog[i];
  endtask

  task automatic restart(input int w, input bit st);
    rst   = 1'b1;
    waits = w;
    stall = st;
    @(negedge clk);
    xlog.delete();
    rlog.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_retires(input int n, input int budget, input string name);
    int k = 0;
    while (rlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_bit({name, "_retires"}, rlog.size() >= n, 1'b1);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    mv[0] = '{32'h100, 32'hABCD_1234};  // addu
    mv[1] = '{32'h104, 32'h0000_0001};  // slt signed
    mv[2] = '{32'h108, 32'h5433_1234};  // subu wraps
    mv[3] = '{32'h10C, 32'hABCD_1234};  // or
    mv[4] = '{32'h110, 32'h0000_1234};  // and
    mv[5] = '{32'h114, 32'h0000_1234};  // $0 reads 0 after write attempt
    mv[6] = '{32'h118, 32'hFFFF_FFFF};  // addiu sext
    xexp[0]  = '{1'b0, 32'h3000, 32'h0};
    xexp[1]  = '{1'b0, 32'h3004, 32'h0};
    xexp[2]  = '{1'b0, 32'h3008, 32'h0};
    xexp[3]  = '{1'b1, 32'h0008, 32'hABCD_1234};
    xexp[4]  = '{1'b0, 32'h300C, 32'h0};
    xexp[5]  = '{1'b0, 32'h0008, 32'h0};
    xexp[6]  = '{1'b0, 32'h3010, 32'h0};
    xexp[7]  = '{1'b0, 32'h3014, 32'h0};
    xexp[8]  = '{1'b1, 32'h0010, 32'hABCD_1234};
    xexp[9]  = '{1'b0, 32'h3018, 32'h0};
    xexp[10] = '{1'b0, 32'h3020, 32'h0};
    xexp[11] = '{1'b0, 32'h3000, 32'h0};

    // Reset state
    for (int i = 0; i < 4096; i++) mem[i] = Sentinel;
    run(2);
    check_bit("rst_req", mem_req, 1'b0);
    check_bit("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check_bit("rst_retired", retired, 1'b0);
    check_bit("rst_halted", halted, 1'b0);
    check_bit("rst_bus_err", bus_err, 1'b0);

    // ALU program, zero wait
    prog = {32'h3401_1234, 32'h3C02_ABCD, 32'h0022_1821, 32'h0041_202A, 32'h0022_3023,
            32'h0022_3825, 32'h2408_FFFF, 32'h0101_4824, 32'h2400_0005, 32'h0001_5021,
            32'hAC03_0100, 32'hAC04_0104, 32'hAC06_0108, 32'hAC07_010C, 32'hAC09_0110,
            32'hAC0A_0114, 32'hAC08_0118, 32'h1000_FFFF};
    load_prog();
    restart(0, 1'b0);
    #1;
    check_bit("boot_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    check_bit("fetch_req", mem_req, 1'b1);
    check("fetch_addr", mem_addr, 32'h3000);
    wait_retires(20, 300, "alu");
    for (int i = 1; i < 4 && i < rlog.size(); i++)
      check($sformatf("alu_period%0d", i), 32'(rlog[i] - rlog[i-1]), 32'd4);
    if (rlog.size() > 11) check("sw_period", 32'(rlog[11] - rlog[10]), 32'd4);
    for (int i = 0; i < 7; i++)
      check($sformatf("alu_mem%h", mv[i].addr), mem[mv[i].addr[13:2]], mv[i].exp);
    reqs = 0;
    while (!mem_req && reqs < 10) begin
      @(negedge clk);
      reqs++;
    end
    check("beq_self_loop", mem_addr, 32'h3044);

    // Load/store with three wait states, branches and jump
    prog = {32'h3C03_ABCD, 32'h3463_1234, 32'hAC03_0008, 32'h8C05_0008, 32'h10A0_0002,
            32'hAC05_0010, 32'h10A3_0001, 32'hAC05_0014, 32'h0800_0C00};
    load_prog();
    restart(3, 1'b0);
    wait_retires(9, 400, "mem");
    check_bit("xlog_size", xlog.size() >= 12, 1'b1);
    for (int i = 0; i < 12 && i < xlog.size(); i++) begin
      check_bit($sformatf("xfer%0d_we", i), xlog[i].we, xexp[i].we);
      check($sformatf("xfer%0d_addr", i), xlog[i].addr, xexp[i].addr);
      if (xexp[i].we) check($sformatf("xfer%0d_data", i), xlog[i].data, xexp[i].data);
    end
    if (rlog.size() > 7) begin
      check("sw_wait_len", 32'(rlog[2] - rlog[1]), 32'd10);
      check("lw_wait_len", 32'(rlog[3] - rlog[2]), 32'd11);
      check("j_wait_len", 32'(rlog[7] - rlog[6]), 32'd5);
    end
    check("lw_result", mem[4], 32'hABCD_1234);
    check("beq_skipped", mem[5], Sentinel);

    // Timeout: memory never ready, WAIT_MAX=4
    restart(0, 1'b1);
    reqs = 0;
    for (int i = 0; i < 20 && !halted; i++) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("timeout_req_cycles", 32'(reqs), 32'd4);
    check_bit("timeout_halted", halted, 1'b1);
    check_bit("timeout_bus_err", bus_err, 1'b1);
    check_bit("timeout_req_drop", mem_req, 1'b0);

    // Reset mid-transfer, then illegal opcode
    prog = {32'hFC00_0000};
    load_prog();
    restart(0, 1'b1);
    run(2);
    check_bit("stalled_req", mem_req, 1'b1);
    restart(0, 1'b0);
    #1;
    check_bit("rerst_halted", halted, 1'b0);
    check_bit("rerst_bus_err", bus_err, 1'b0);
    run(12);
    check_bit("illegal_halted", halted, 1'b1);
    check_bit("illegal_bus_err", bus_err, 1'b0);
    check_bit("illegal_req", mem_req, 1'b0);
    check("illegal_xfers", 32'(xlog.size()), 32'd1);
    check("illegal_retires", 32'(rlog.size()), 32'd0);

    // jal / jr
    prog = {32'h0C00_0C03, 32'h1000_FFFF, 32'h0000_0000, 32'hAC1F_0020, 32'h03E0_0008};
    load_prog();
    restart(0, 1'b0);
`ifdef MIPS_MC_LINK_EN
    wait_retires(4, 100, "link");
    check("jal_link", mem[8], 32'h0000_3004);
    if (xlog.size() > 4) begin
      check("jal_target", xlog[1].addr, 32'h300C);
      check("jr_return", xlog[4].addr, 32'h3004);
    end else begin
      check("link_xfers", 32'(xlog.size()), 32'd5);
    end
    if (rlog.size() > 2) check("jr_len", 32'(rlog[2] - rlog[1]), 32'd2);
    check_bit("link_halted", halted, 1'b0);
`else
    run(12);
    check_bit("jal_halted", halted, 1'b1);
    check("jal_xfers", 32'(xlog.size()), 32'd1);
    check("jal_no_store", mem[8], Sentinel);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
